mult_datapath: RTL and testbench
================================

MULT_DATAPATH -- requirements
Module: mult_datapath

Parameters
REQ-001 W, 4, operand width in bits; product width is 2W.

Interface
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 clr  input  1  strobe: clear product, carry, counter, flags.
REQ-005 ld  input  1  strobe: load operands.
REQ-006 ldp  input  1  strobe: conditional add of multiplicand into product high half.
REQ-007 shp  input  1  strobe: shift {carry, product} right by one.
REQ-008 shb  input  1  strobe: shift multiplier right by one.
REQ-009 a_in  input  W  multiplicand, sampled on ld.
REQ-010 b_in  input  W  multiplier, sampled on ld.
REQ-011 p_out  output  2W  product register P, driven directly from the register.
REQ-012 b_lsb  output  1  current multiplier LSB, B[0].
REQ-013 done  output  1  high once W shp strobes have completed since the last ld.
REQ-014 err  output  1  sticky protocol-error flag.

Function
REQ-015 Registers: A (W bits), B (W bits), P (2W bits), carry C (1 bit), shift counter CNT (clog2(W)+1 bits), monitor state MS.
REQ-016 Strobe priority when more than one is high: clr > ld > ldp > shp > shb; only the highest is applied and err sets on that edge.
REQ-017 clr: P=0, C=0, CNT=0, done=0, err=0; A and B unchanged.
REQ-018 ld: A=a_in, B=b_in, CNT=0, done=0; P and C unchanged.
REQ-019 ldp with B[0]=1: {C,P[2W-1:W]} = P[2W-1:W] + A as a (W+1)-bit sum; P[W-1:0] unchanged.
REQ-020 ldp with B[0]=0: P and C unchanged.
REQ-021 shp: P = {C, P[2W-1:1]}; C=0; CNT increments, saturating at W.
REQ-022 shb: B = {0, B[W-1:1]}.
REQ-023 done goes high on the edge where CNT becomes W and holds until clr, ld or reset.
REQ-024 No strobe high: all registers hold.
REQ-025 Monitor states: IDLE, CLRD, LOADED, ACC, SHFP, SHFB.
REQ-026 Monitor legal transitions: any state + clr -> CLRD; CLRD + ld -> LOADED; LOADED + ldp -> ACC; ACC + shp -> SHFP; SHFP + shb -> SHFB; SHFB + ldp -> ACC (only while done=0).
REQ-027 Any other strobe is illegal: err sets the next edge, MS is unchanged, and the datapath still applies the strobe per REQ-017..022.
REQ-028 Strobes are also illegal while done=1, except clr and ld.
REQ-029 ld while done=1 is legal only from SHFB or SHFP (restart without clr); MS -> LOADED.
REQ-030 The multi-strobe case sets err; MS does not change.
REQ-031 err is sticky until clr or reset; clr in the same cycle as any error condition leaves err=0.
REQ-032 Arithmetic is unsigned. No overflow is possible: the final product always fits in 2W bits.

Reset
REQ-033 reset asynchronously forces A=0, B=0, P=0, C=0, CNT=0, done=0, err=0, MS=IDLE.
REQ-034 After reset, p_out=0, b_lsb=0, done=0 and err=0 until the first clk edge with reset low.
REQ-035 reset asserted mid-operation aborts the operation with no partial update on any subsequent edge while reset is high.

Verification
REQ-036 Multiply: reset; clr; ld a_in=13, b_in=11; then 4x(ldp, shp, shb) -> P after each shp = 104, 156, 78, 143. Final p_out=143 (0x8F), done=1 after the 4th shp, err=0.
REQ-037 Zero/full operands: a_in=0, b_in=15 -> p_out=0. a_in=15, b_in=15 -> p_out=225, with C=1 produced on the 2nd-4th ldp. err=0 in both cases.
REQ-038 Illegal order: reset; ld without clr -> err=1 next edge, A and B still loaded. Then clr -> err=0, MS=CLRD.
REQ-039 Simultaneous strobes: ldp and shp high together in ACC-legal context -> only ldp applied, err=1, MS unchanged.
REQ-040 Extra strobe after done: one more ldp after the 4th shb -> err=1, and P changes only if B[0]=1 (B=0 here, so P holds 143).
REQ-041 Reset mid-operation: assert reset asynchronously after the 2nd shp -> p_out=0, done=0, MS=IDLE immediately, with no clock edge needed.

Source files
------------

// File: rtl/mult_datapath_if.sv
// -----------------------------------------------------------------------------
// mult_datapath_if
// Strobe/operand/result bundle for the shift-and-add multiplier datapath.
//   i_clr, i_ld, i_ldp, i_shp, i_shb : one-cycle control strobes (controller -> datapath)
//   i_a_in, i_b_in                   : multiplicand / multiplier operands, W bits
//   o_p_out                          : product register, 2W bits
//   o_b_lsb                          : current multiplier LSB
//   o_done                           : all W product shifts completed since the last load
//   o_err                            : sticky protocol-error flag
// The controller side uses modport master; the datapath uses modport slave.
// -----------------------------------------------------------------------------
interface mult_datapath_if #(
  parameter int W = 4
);
  logic             i_clr;
  logic             i_ld;
  logic             i_ldp;
  logic             i_shp;
  logic             i_shb;
  logic [W-1:0]     i_a_in;
  logic [W-1:0]     i_b_in;
  logic [2*W-1:0]   o_p_out;
  logic             o_b_lsb;
  logic             o_done;
  logic             o_err;

  modport master (
    output i_clr, i_ld, i_ldp, i_shp, i_shb, i_a_in, i_b_in,
    input  o_p_out, o_b_lsb, o_done, o_err
  );

  modport slave (
    input  i_clr, i_ld, i_ldp, i_shp, i_shb, i_a_in, i_b_in,
    output o_p_out, o_b_lsb, o_done, o_err
  );
endinterface

// File: rtl/mult_datapath.sv
// -----------------------------------------------------------------------------
// mult_datapath
// Unsigned shift-and-add multiplier datapath driven by external strobes, with a
// protocol monitor that flags strobes issued out of the expected order.
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous, active-high reset
//   bus   : mult_datapath_if.slave (strobes, operands, product, b_lsb, done, err)
// Registers: A (multiplicand), B (multiplier), P (product), C (add carry),
// CNT (product shift counter, saturates at W), done, err, monitor state MS.
// Exactly one strobe is applied per edge, chosen by priority
// clr > ld > ldp > shp > shb; more than one strobe high is itself an error.
// -----------------------------------------------------------------------------
module mult_datapath #(
  parameter int W = 4
) (
  input  logic          clk,
  input  logic          reset,
  mult_datapath_if.slave bus
);

  localparam int              CW      = $clog2(W) + 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(W);

  typedef enum logic [2:0] {
    MS_IDLE,
    MS_CLRD,
    MS_LOADED,
    MS_ACC,
    MS_SHFP,
    MS_SHFB
  } ms_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CLR,
    SEL_LD,
    SEL_LDP,
    SEL_SHP,
    SEL_SHB
  } sel_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_p;
  logic           r_c;
  logic [CW-1:0]  r_cnt;
  logic           r_done;
  logic           r_err;
  ms_t            r_ms;

  // ---------------------------------------------------------------------------
  // Strobe decode
  // ---------------------------------------------------------------------------
  logic [4:0]     w_stb;
  logic           w_multi;
  sel_t           w_sel;
  logic [W:0]     w_sum;
  logic [CW-1:0]  w_cnt_inc;

  assign w_stb   = {bus.i_clr, bus.i_ld, bus.i_ldp, bus.i_shp, bus.i_shb};
  assign w_multi = ($countones(w_stb) > 1);

  // High half of P plus A as a (W+1)-bit sum; bit W becomes the carry.
  assign w_sum     = {1'b0, r_p[2*W-1:W]} + {1'b0, r_a};
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_sel = SEL_NONE;
    if      (bus.i_clr) w_sel = SEL_CLR;
    else if (bus.i_ld)  w_sel = SEL_LD;
    else if (bus.i_ldp) w_sel = SEL_LDP;
    else if (bus.i_shp) w_sel = SEL_SHP;
    else if (bus.i_shb) w_sel = SEL_SHB;
  end

  // ---------------------------------------------------------------------------
  // Protocol monitor: next state and legality of the selected strobe
  // ---------------------------------------------------------------------------
  ms_t  w_ms_next;
  logic w_legal;

  always_comb begin
    w_ms_next = r_ms;
    w_legal   = 1'b0;
    unique case (w_sel)
      SEL_NONE: w_legal = 1'b1;
      SEL_CLR: begin
        w_legal   = 1'b1;
        w_ms_next = MS_CLRD;
      end
      SEL_LD: begin
        // After a completed pass, a new load may restart without a clear.
        if ((r_ms == MS_CLRD && !r_done) ||
            (r_done && (r_ms == MS_SHFB || r_ms == MS_SHFP))) begin
          w_legal   = 1'b1;
          w_ms_next = MS_LOADED;
        end
      end
      SEL_LDP: begin
        if (!r_done && (r_ms == MS_LOADED || r_ms == MS_SHFB)) begin
          w_legal   = 1'b1;
          w_ms_next = MS_ACC;
        end
      end
      SEL_SHP: begin
        if (!r_done && r_ms == MS_ACC) begin
          w_legal   = 1'b1;
          w_ms_next = MS_SHFP;
        end
      end
      SEL_SHB: begin
        // The multiplier shift that closes the final iteration follows the
        // shp that raised done, so shb out of SHFP stays legal while done=1.
        if (r_ms == MS_SHFP) begin
          w_legal   = 1'b1;
          w_ms_next = MS_SHFB;
        end
      end
      default: ;
    endcase

    // Several strobes at once is an error (clr still wins and clears err).
    if (w_multi && w_sel != SEL_CLR) begin
      w_legal   = 1'b0;
      w_ms_next = r_ms;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_p    <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_ms   <= MS_IDLE;
    end else begin
      r_ms <= w_ms_next;

      if (w_sel == SEL_CLR)  r_err <= 1'b0;
      else if (!w_legal)     r_err <= 1'b1;

      unique case (w_sel)
        SEL_CLR: begin
          r_p    <= '0;
          r_c    <= 1'b0;
          r_cnt  <= '0;
          r_done <= 1'b0;
        end
        SEL_LD: begin
          r_a    <= bus.i_a_in;
          r_b    <= bus.i_b_in;
          r_cnt  <= '0;
          r_done <= 1'b0;
        end
        SEL_LDP: begin
          if (r_b[0]) begin
            r_c            <= w_sum[W];
            r_p[2*W-1:W]   <= w_sum[W-1:0];
          end
        end
        SEL_SHP: begin
          r_p   <= {r_c, r_p[2*W-1:1]};
          r_c   <= 1'b0;
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc == CNT_MAX) r_done <= 1'b1;
        end
        SEL_SHB: r_b <= {1'b0, r_b[W-1:1]};
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.o_p_out = r_p;
  assign bus.o_b_lsb = r_b[0];
  assign bus.o_done  = r_done;
  assign bus.o_err   = r_err;

endmodule

// File: tb/tb_mult_datapath.sv
// -----------------------------------------------------------------------------
// tb_mult_datapath
// Self-checking bench for mult_datapath (W=4): a table of single-cycle strobe
// vectors with hand-computed expected outputs, followed by hand-written
// sequences for illegal ordering, simultaneous strobes and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_mult_datapath;

  localparam int W = 4;

  // Strobe codes, bit order {clr, ld, ldp, shp, shb}
  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_CLR  = 5'b10000;
  localparam logic [4:0] S_LD   = 5'b01000;
  localparam logic [4:0] S_LDP  = 5'b00100;
  localparam logic [4:0] S_SHP  = 5'b00010;
  localparam logic [4:0] S_SHB  = 5'b00001;

  typedef struct {
    logic [4:0]   stb;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [7:0]   p;
    logic         lsb;
    logic         done;
    logic         err;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  mult_datapath_if #(.W(W)) bus ();

  mult_datapath #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] stb, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [7:0] p, input logic lsb, input logic done, input logic err);
    vec_t v;
    v.stb = stb; v.a = a; v.b = b; v.p = p; v.lsb = lsb; v.done = done; v.err = err;
    vecs.push_back(v);
  endtask

  // Drive one strobe pattern for a single clock edge; returns 1 ns after it.
  task automatic pulse(input logic [4:0] stb, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    {bus.i_clr, bus.i_ld, bus.i_ldp, bus.i_shp, bus.i_shb} = stb;
    bus.i_a_in = a;
    bus.i_b_in = b;
    @(posedge clk);
    #1;
    {bus.i_clr, bus.i_ld, bus.i_ldp, bus.i_shp, bus.i_shb} = S_NONE;
  endtask

  function automatic logic [15:0] outs();
    return {5'd0, bus.o_p_out, bus.o_b_lsb, bus.o_done, bus.o_err};
  endfunction

  function automatic logic [15:0] pack(input logic [7:0] p, input logic lsb,
                                       input logic done, input logic err);
    return {5'd0, p, lsb, done, err};
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    {bus.i_clr, bus.i_ld, bus.i_ldp, bus.i_shp, bus.i_shb} = S_NONE;
    bus.i_a_in = '0;
    bus.i_b_in = '0;

    // ------------------------------------------------------------ vector table
    // 13 x 11: P after each shp = 104, 156, 78, 143
    add(S_CLR,  0,  0,   0, 0, 0, 0);
    add(S_LD,  13, 11,   0, 1, 0, 0);
    add(S_LDP,  0,  0, 208, 1, 0, 0);
    add(S_SHP,  0,  0, 104, 1, 0, 0);
    add(S_SHB,  0,  0, 104, 1, 0, 0);
    add(S_LDP,  0,  0,  56, 1, 0, 0);
    add(S_SHP,  0,  0, 156, 1, 0, 0);
    add(S_SHB,  0,  0, 156, 0, 0, 0);
    add(S_LDP,  0,  0, 156, 0, 0, 0);
    add(S_SHP,  0,  0,  78, 0, 0, 0);
    add(S_SHB,  0,  0,  78, 1, 0, 0);
    add(S_LDP,  0,  0,  30, 1, 0, 0);
    add(S_SHP,  0,  0, 143, 1, 1, 0);
    add(S_SHB,  0,  0, 143, 0, 1, 0);
    add(S_NONE, 0,  0, 143, 0, 1, 0);
    // Extra ldp after done: illegal, B[0]=0 so P holds
    add(S_LDP,  0,  0, 143, 0, 1, 1);
    // 0 x 15
    add(S_CLR,  0,  0,   0, 0, 0, 0);
    add(S_LD,   0, 15,   0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      add(S_LDP, 0, 0, 0, 1, 0, 0);
      add(S_SHP, 0, 0, 0, 1, (i == 3), 0);
      add(S_SHB, 0, 0, 0, (i != 3), (i == 3), 0);
    end
    // 15 x 15: carry out of the 2nd-4th ldp shows up in the shifted P
    add(S_CLR,  0,  0,   0, 0, 0, 0);
    add(S_LD,  15, 15,   0, 1, 0, 0);
    add(S_LDP,  0,  0, 240, 1, 0, 0);
    add(S_SHP,  0,  0, 120, 1, 0, 0);
    add(S_SHB,  0,  0, 120, 1, 0, 0);
    add(S_LDP,  0,  0, 104, 1, 0, 0);
    add(S_SHP,  0,  0, 180, 1, 0, 0);
    add(S_SHB,  0,  0, 180, 1, 0, 0);
    add(S_LDP,  0,  0, 164, 1, 0, 0);
    add(S_SHP,  0,  0, 210, 1, 0, 0);
    add(S_SHB,  0,  0, 210, 1, 0, 0);
    add(S_LDP,  0,  0, 194, 1, 0, 0);
    add(S_SHP,  0,  0, 225, 1, 1, 0);
    add(S_SHB,  0,  0, 225, 0, 1, 0);
    // Restart load from SHFB while done=1 is legal; P/C untouched
    add(S_LD,   9,  6, 225, 0, 0, 0);
    add(S_LDP,  0,  0, 225, 0, 0, 0);

    // ---------------------------------------------------------------- reset
    reset = 1'b1;
    #2;
    check("reset_outputs", outs(), pack(8'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0;

    // ---------------------------------------------------------- apply table
    for (int i = 0; i < vecs.size(); i++) begin
      pulse(vecs[i].stb, vecs[i].a, vecs[i].b);
      check($sformatf("vec[%0d]", i), outs(),
            pack(vecs[i].p, vecs[i].lsb, vecs[i].done, vecs[i].err));
    end

    // ----------------------------------------- illegal order: ld without clr
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    pulse(S_LD, 4'd7, 4'd9);
    check("ld_no_clr_err", outs(), pack(8'd0, 1'b1, 1'b0, 1'b1));
    pulse(S_NONE, 4'd0, 4'd0);
    check("err_sticky", {15'd0, bus.o_err}, 16'd1);
    pulse(S_CLR, 4'd0, 4'd0);
    check("clr_clears_err", outs(), pack(8'd0, 1'b1, 1'b0, 1'b0));
    // MS is CLRD now, so ld is legal
    pulse(S_LD, 4'd7, 4'd8);
    check("ld_after_clr_legal", outs(), pack(8'd0, 1'b0, 1'b0, 1'b0));

    // ---------------------------------------------- simultaneous ldp + shp
    pulse(S_CLR, 4'd0, 4'd0);
    pulse(S_LD, 4'd5, 4'd3);
    pulse(S_LDP | S_SHP, 4'd0, 4'd0);
    check("multi_strobe_ldp_only", outs(), pack(8'd80, 1'b1, 1'b0, 1'b1));

    // ------------------------------------------ clr together with an error
    pulse(S_CLR | S_SHB, 4'd0, 4'd0);
    check("clr_with_multi", outs(), pack(8'd0, 1'b1, 1'b0, 1'b0));

    // ------------------------------------- asynchronous reset mid-operation
    pulse(S_LD, 4'd13, 4'd11);
    pulse(S_LDP, 4'd0, 4'd0);
    pulse(S_SHP, 4'd0, 4'd0);
    pulse(S_SHB, 4'd0, 4'd0);
    pulse(S_LDP, 4'd0, 4'd0);
    pulse(S_SHP, 4'd0, 4'd0);
    check("pre_reset_p", outs(), pack(8'd156, 1'b1, 1'b0, 1'b0));
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_immediate", outs(), pack(8'd0, 1'b0, 1'b0, 1'b0));
    // Strobes during a held reset must not update anything
    pulse(S_LD, 4'd15, 4'd15);
    check("reset_held_no_update", outs(), pack(8'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    // MS back in IDLE: ld without clr is illegal
    pulse(S_LD, 4'd3, 4'd3);
    check("ms_idle_after_reset", outs(), pack(8'd0, 1'b1, 1'b0, 1'b1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
